// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters (CPU and
// DMA/debug loader) and the unified memory port.
// The slave modport is the arbiter's view: it serves the request channels
// and drives the memory strobe.  The master modport is the surrounding
// system's view: requesters, memory and grant observers.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_stall;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] dma_rdata;
    logic          dma_ack;
    logic          dma_stall;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [1:0]    gnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack, dma_stall,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output gnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack, dma_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  gnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single unified memory port of the
// multicycle core.  One transaction at a time: grant in IDLE, a single
// mem_en cycle in ACCESS, MEM_LAT-cycle read wait in WAIT, and a one-cycle
// acknowledge in DONE.  Ties are broken round-robin; the CPU wins the
// first tie after reset.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

    state_t        state;
    state_t        state_next;

    logic [1:0]    owner;
    logic          last_dma;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    lat_cnt;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dma_rdata_q;

    logic          grant_cpu;
    logic          grant_dma;
    logic          cpu_ack_int;
    logic          dma_ack_int;

    // Next-state and grant decision; the CPU wins a tie only when the DMA
    // port owned the previous transaction.
    always_comb begin
        state_next = state;
        grant_cpu  = 1'b0;
        grant_dma  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_req && (!bus.dma_req || last_dma)) begin
                    grant_cpu = 1'b1;
                end else if (bus.dma_req) begin
                    grant_dma = 1'b1;
                end
                if (grant_cpu || grant_dma) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: state_next = we_q ? DONE : WAIT;
            WAIT: begin
                if (lat_cnt == 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Transaction capture, latency countdown and read-data return; the
    // captured request is frozen for the whole transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner       <= 2'b00;
            last_dma    <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lat_cnt     <= 4'd0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_cpu) begin
                        owner    <= 2'b01;
                        last_dma <= 1'b0;
                        we_q     <= bus.cpu_we;
                        addr_q   <= bus.cpu_addr;
                        wdata_q  <= bus.cpu_wdata;
                    end else if (grant_dma) begin
                        owner    <= 2'b10;
                        last_dma <= 1'b1;
                        we_q     <= bus.dma_we;
                        addr_q   <= bus.dma_addr;
                        wdata_q  <= bus.dma_wdata;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        lat_cnt <= LAT_INIT;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        if (owner[0]) begin
                            cpu_rdata_q <= bus.mem_rdata;
                        end
                        if (owner[1]) begin
                            dma_rdata_q <= bus.mem_rdata;
                        end
                    end
                end
                DONE: begin
                    owner <= 2'b00;
                end
                default: begin
                    owner <= 2'b00;
                end
            endcase
        end
    end

    assign cpu_ack_int   = (state == DONE) && owner[0];
    assign dma_ack_int   = (state == DONE) && owner[1];

    assign bus.mem_en    = (state == ACCESS);
    assign bus.mem_we    = (state == ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.gnt       = owner;

    assign bus.cpu_ack   = cpu_ack_int;
    assign bus.dma_ack   = dma_ack_int;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_int;
    assign bus.dma_stall = bus.dma_req & ~dma_ack_int;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: one instance with MEM_LAT=1 and one
// with MEM_LAT=4, each attached to a small memory model whose read data is
// valid only in the single cycle the arbiter is meant to sample it.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [1:0]  loadSel = 2'd0;
    logic [7:0]  loadIdx = 8'd0;
    logic [31:0] loadData = 32'd0;

    logic [31:0] mem1 [0:255];
    logic [31:0] mem4 [0:255];
    logic [3:0]  n1 = 4'd0;
    logic [3:0]  n4 = 4'd0;

    mem_arbiter_if #(.AW(32), .DW(32)) bus1 ();
    mem_arbiter_if #(.AW(32), .DW(32)) bus4 ();

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    always #5 clk = ~clk;

    // Memory model for the MEM_LAT=1 instance: backdoor preload, writes on
    // mem_en, and a read-age counter started by each read strobe.
    always @(posedge clk) begin
        if (loadSel == 2'd1) mem1[loadIdx] <= loadData;
        if (bus1.mem_en && bus1.mem_we) mem1[bus1.mem_addr[9:2]] <= bus1.mem_wdata;
        if (bus1.mem_en && !bus1.mem_we) n1 <= 4'd1;
        else if (n1 != 4'd0 && n1 != 4'd15) n1 <= n1 + 4'd1;
    end
    assign bus1.mem_rdata = (n1 == 4'd1) ? mem1[bus1.mem_addr[9:2]] : 32'hBAD0BAD0;

    // Memory model for the MEM_LAT=4 instance.
    always @(posedge clk) begin
        if (loadSel == 2'd2) mem4[loadIdx] <= loadData;
        if (bus4.mem_en && bus4.mem_we) mem4[bus4.mem_addr[9:2]] <= bus4.mem_wdata;
        if (bus4.mem_en && !bus4.mem_we) n4 <= 4'd1;
        else if (n4 != 4'd0 && n4 != 4'd15) n4 <= n4 + 4'd1;
    end
    assign bus4.mem_rdata = (n4 == 4'd4) ? mem4[bus4.mem_addr[9:2]] : 32'hBAD0BAD0;

    task automatic nextCycle;
        @(negedge clk);
    endtask

    // sel: 0 = dut1 CPU, 1 = dut1 DMA, 2 = dut4 CPU, 3 = dut4 DMA
    task automatic applyStimulus(input int sel, input logic req, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        case (sel)
            0: begin bus1.cpu_req = req; bus1.cpu_we = we; bus1.cpu_addr = addr; bus1.cpu_wdata = wdata; end
            1: begin bus1.dma_req = req; bus1.dma_we = we; bus1.dma_addr = addr; bus1.dma_wdata = wdata; end
            2: begin bus4.cpu_req = req; bus4.cpu_we = we; bus4.cpu_addr = addr; bus4.cpu_wdata = wdata; end
            default: begin bus4.dma_req = req; bus4.dma_we = we; bus4.dma_addr = addr; bus4.dma_wdata = wdata; end
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected)
        else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int s = 0; s < 4; s++) applyStimulus(s, 1'b0, 1'b0, 32'd0, 32'd0);

        // Preload memory contents while the arbiters are held in reset.
        nextCycle; loadSel = 2'd1; loadIdx = 8'd16;  loadData = 32'hDEADBEEF;
        nextCycle; loadSel = 2'd2; loadIdx = 8'd32;  loadData = 32'hCAFEF00D;
        nextCycle; loadSel = 2'd2; loadIdx = 8'd33;  loadData = 32'h0BADC0DE;
        nextCycle; loadSel = 2'd2; loadIdx = 8'd128; loadData = 32'h55AA55AA;
        nextCycle; loadSel = 2'd0; #1;
        checkOutput("rst_gnt",       32'(bus1.gnt),       32'd0);
        checkOutput("rst_mem_en",    32'(bus1.mem_en),    32'd0);
        checkOutput("rst_mem_we",    32'(bus1.mem_we),    32'd0);
        checkOutput("rst_mem_addr",  bus1.mem_addr,       32'd0);
        checkOutput("rst_mem_wdata", bus1.mem_wdata,      32'd0);
        checkOutput("rst_cpu_rdata", bus1.cpu_rdata,      32'd0);
        checkOutput("rst_dma_rdata", bus1.dma_rdata,      32'd0);
        checkOutput("rst_cpu_ack",   32'(bus1.cpu_ack),   32'd0);
        checkOutput("rst_dma_ack",   32'(bus1.dma_ack),   32'd0);
        checkOutput("rst4_gnt",      32'(bus4.gnt),       32'd0);
        reset = 1'b0;

        $display("[TB] CPU read, MEM_LAT=1");
        nextCycle; applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'd0); #1;
        checkOutput("rd1_c0_stall",  32'(bus1.cpu_stall), 32'd1);
        checkOutput("rd1_c0_mem_en", 32'(bus1.mem_en),    32'd0);
        checkOutput("rd1_c0_gnt",    32'(bus1.gnt),       32'd0);
        nextCycle; #1;
        checkOutput("rd1_c1_mem_en", 32'(bus1.mem_en),    32'd1);
        checkOutput("rd1_c1_mem_we", 32'(bus1.mem_we),    32'd0);
        checkOutput("rd1_c1_addr",   bus1.mem_addr,       32'h40);
        checkOutput("rd1_c1_gnt",    32'(bus1.gnt),       32'd1);
        checkOutput("rd1_c1_stall",  32'(bus1.cpu_stall), 32'd1);
        nextCycle; #1;
        checkOutput("rd1_c2_mem_en", 32'(bus1.mem_en),    32'd0);
        checkOutput("rd1_c2_ack",    32'(bus1.cpu_ack),   32'd0);
        checkOutput("rd1_c2_stall",  32'(bus1.cpu_stall), 32'd1);
        nextCycle; #1;
        checkOutput("rd1_c3_ack",    32'(bus1.cpu_ack),   32'd1);
        checkOutput("rd1_c3_rdata",  bus1.cpu_rdata,      32'hDEADBEEF);
        checkOutput("rd1_c3_stall",  32'(bus1.cpu_stall), 32'd0);
        applyStimulus(0, 1'b0, 1'b0, 32'h40, 32'd0);
        nextCycle; #1;
        checkOutput("rd1_c4_ack",    32'(bus1.cpu_ack),   32'd0);
        checkOutput("rd1_c4_gnt",    32'(bus1.gnt),       32'd0);
        checkOutput("rd1_c4_hold",   bus1.cpu_rdata,      32'hDEADBEEF);

        $display("[TB] DMA write");
        applyStimulus(1, 1'b1, 1'b1, 32'h100, 32'h12345678);
        nextCycle; #1;
        checkOutput("wr_c1_mem_en",  32'(bus1.mem_en),    32'd1);
        checkOutput("wr_c1_mem_we",  32'(bus1.mem_we),    32'd1);
        checkOutput("wr_c1_addr",    bus1.mem_addr,       32'h100);
        checkOutput("wr_c1_wdata",   bus1.mem_wdata,      32'h12345678);
        checkOutput("wr_c1_gnt",     32'(bus1.gnt),       32'd2);
        checkOutput("wr_c1_ack",     32'(bus1.dma_ack),   32'd0);
        nextCycle; #1;
        checkOutput("wr_c2_ack",     32'(bus1.dma_ack),   32'd1);
        checkOutput("wr_c2_cpu_ack", 32'(bus1.cpu_ack),   32'd0);
        applyStimulus(1, 1'b0, 1'b0, 32'h100, 32'd0);
        nextCycle; #1;
        checkOutput("wr_mem_content", mem1[64],           32'h12345678);
        checkOutput("wr_c3_ack",     32'(bus1.dma_ack),   32'd0);
        checkOutput("wr_c3_mem_we",  32'(bus1.mem_we),    32'd0);
        checkOutput("wr_dma_rdata",  bus1.dma_rdata,      32'd0);

        // A CPU write leaves last_owner = CPU before the mid-run reset.
        applyStimulus(0, 1'b1, 1'b1, 32'h44, 32'hA5A5A5A5);
        nextCycle; #1;
        checkOutput("cwr_c1_gnt",    32'(bus1.gnt),       32'd1);
        checkOutput("cwr_c1_addr",   bus1.mem_addr,       32'h44);
        nextCycle; #1;
        checkOutput("cwr_c2_ack",    32'(bus1.cpu_ack),   32'd1);
        applyStimulus(0, 1'b0, 1'b0, 32'h44, 32'd0);
        nextCycle; #1;
        checkOutput("cwr_mem_content", mem1[17],          32'hA5A5A5A5);

        $display("[TB] Mid-run reset");
        reset = 1'b1; #1;
        checkOutput("mrst_mem_addr",  bus1.mem_addr,      32'd0);
        checkOutput("mrst_mem_wdata", bus1.mem_wdata,     32'd0);
        checkOutput("mrst_cpu_rdata", bus1.cpu_rdata,     32'd0);
        checkOutput("mrst_gnt",       32'(bus1.gnt),      32'd0);
        nextCycle; reset = 1'b0;

        $display("[TB] Contention, four transactions");
        applyStimulus(0, 1'b1, 1'b1, 32'h10, 32'h11111111);
        applyStimulus(1, 1'b1, 1'b1, 32'h20, 32'h22222222);
        for (int k = 0; k < 4; k++) begin
            nextCycle; #1;
            checkOutput($sformatf("cont%0d_gnt", k),    32'(bus1.gnt),    (k % 2 == 0) ? 32'd1 : 32'd2);
            checkOutput($sformatf("cont%0d_addr", k),   bus1.mem_addr,    (k % 2 == 0) ? 32'h10 : 32'h20);
            checkOutput($sformatf("cont%0d_mem_en", k), 32'(bus1.mem_en), 32'd1);
            nextCycle; #1;
            checkOutput($sformatf("cont%0d_cpu_ack", k), 32'(bus1.cpu_ack), (k % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("cont%0d_dma_ack", k), 32'(bus1.dma_ack), (k % 2 == 0) ? 32'd0 : 32'd1);
            if (k == 3) begin
                applyStimulus(0, 1'b0, 1'b0, 32'h10, 32'd0);
                applyStimulus(1, 1'b0, 1'b0, 32'h20, 32'd0);
            end
            nextCycle; #1;
            checkOutput($sformatf("cont%0d_idle_gnt", k), 32'(bus1.gnt),  32'd0);
            checkOutput($sformatf("cont%0d_idle_en", k),  32'(bus1.mem_en), 32'd0);
        end
        nextCycle; #1;
        checkOutput("cont_quiet_en", 32'(bus1.mem_en),    32'd0);
        checkOutput("cont_mem_cpu",  mem1[4],             32'h11111111);
        checkOutput("cont_mem_dma",  mem1[8],             32'h22222222);

        $display("[TB] CPU read, MEM_LAT=4, address changed during WAIT");
        applyStimulus(2, 1'b1, 1'b0, 32'h80, 32'd0);
        nextCycle; #1;
        checkOutput("rd4_c1_mem_en", 32'(bus4.mem_en),    32'd1);
        checkOutput("rd4_c1_addr",   bus4.mem_addr,       32'h80);
        checkOutput("rd4_c1_gnt",    32'(bus4.gnt),       32'd1);
        for (int c = 2; c <= 5; c++) begin
            nextCycle;
            if (c == 2) applyStimulus(2, 1'b1, 1'b0, 32'h84, 32'd0);
            #1;
            checkOutput($sformatf("rd4_c%0d_ack", c),   32'(bus4.cpu_ack),   32'd0);
            checkOutput($sformatf("rd4_c%0d_addr", c),  bus4.mem_addr,       32'h80);
            checkOutput($sformatf("rd4_c%0d_stall", c), 32'(bus4.cpu_stall), 32'd1);
        end
        nextCycle; #1;
        checkOutput("rd4_c6_ack",    32'(bus4.cpu_ack),   32'd1);
        checkOutput("rd4_c6_rdata",  bus4.cpu_rdata,      32'hCAFEF00D);
        applyStimulus(2, 1'b0, 1'b0, 32'h84, 32'd0);
        nextCycle; #1;
        checkOutput("rd4_c7_ack",    32'(bus4.cpu_ack),   32'd0);
        checkOutput("rd4_c7_gnt",    32'(bus4.gnt),       32'd0);

        $display("[TB] Abort of a DMA read by reset");
        applyStimulus(3, 1'b1, 1'b0, 32'h200, 32'd0);
        nextCycle; #1;
        checkOutput("abt_c1_gnt",    32'(bus4.gnt),       32'd2);
        checkOutput("abt_c1_mem_en", 32'(bus4.mem_en),    32'd1);
        nextCycle;
        nextCycle;
        reset = 1'b1;
        applyStimulus(3, 1'b0, 1'b0, 32'h200, 32'd0);
        applyStimulus(2, 1'b1, 1'b0, 32'h80, 32'd0);
        #1;
        checkOutput("abt_rst_gnt",   32'(bus4.gnt),       32'd0);
        checkOutput("abt_rst_ack",   32'(bus4.dma_ack),   32'd0);
        checkOutput("abt_rst_stall", 32'(bus4.cpu_stall), 32'd1);
        nextCycle; reset = 1'b0; #1;
        checkOutput("abt_idle_gnt",  32'(bus4.gnt),       32'd0);
        nextCycle; #1;
        checkOutput("abt_regrant_en",  32'(bus4.mem_en),  32'd1);
        checkOutput("abt_regrant_gnt", 32'(bus4.gnt),     32'd1);
        for (int c = 2; c <= 6; c++) begin
            nextCycle; #1;
            checkOutput($sformatf("abt_c%0d_dma_ack", c), 32'(bus4.dma_ack), 32'd0);
            checkOutput($sformatf("abt_c%0d_cpu_ack", c), 32'(bus4.cpu_ack), (c == 6) ? 32'd1 : 32'd0);
        end
        applyStimulus(2, 1'b0, 1'b0, 32'h80, 32'd0);
        checkOutput("abt_cpu_rdata", bus4.cpu_rdata,      32'hCAFEF00D);
        checkOutput("abt_dma_rdata", bus4.dma_rdata,      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
